// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the signed multiply sequencer:
//   - state_t            : sequencer FSM states
//   - DEF_WIDTH          : default operand width
//   - DEF_TIMEOUT_CYCLES : default WAIT timeout (used with MUL_TIMEOUT_EN)
//   - abs_mag()          : unsigned magnitude of a sign-extended operand
// -----------------------------------------------------------------------------
package mul_pkg;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Operands are sign-extended to this width before taking the magnitude,
  // so operand widths up to MAG_MAX_W are supported.
  localparam int MAG_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_PUBLISH = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // Magnitude of a sign-extended two's-complement value. The caller truncates
  // the result to its own width; the most negative operand then maps to its
  // own bit pattern (e.g. -128 -> 0x80 on 8 bits), which is the correct
  // unsigned magnitude.
  function automatic logic [MAG_MAX_W-1:0] abs_mag(input logic [MAG_MAX_W-1:0] x);
    logic [MAG_MAX_W-1:0] neg;
    neg = -x;
    return x[MAG_MAX_W-1] ? neg : x;
  endfunction

endpackage

// File: rtl/mul_operand_latch.sv
// -----------------------------------------------------------------------------
// mul_operand_latch
// Registers one signed operand on load and presents its sign bit and unsigned
// magnitude. Both outputs hold until the next load.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (outputs -> 0)
//   load     in   capture operand this cycle
//   operand  in   [WIDTH] two's-complement operand
//   sgn      out  captured sign bit
//   mag      out  [WIDTH] captured unsigned magnitude
// -----------------------------------------------------------------------------
module mul_operand_latch
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] operand,
  output logic             sgn,
  output logic [WIDTH-1:0] mag
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn <= 1'b0;
      mag <= '0;
    end else if (load) begin
      sgn <= operand[WIDTH-1];
      mag <= WIDTH'(abs_mag(MAG_MAX_W'(signed'(operand))));
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Sequences one signed WIDTHxWIDTH multiply on an external unsigned
// multiplier: latches both operands, issues a one-cycle load with the operand
// magnitudes, waits for the rising edge of mul_done and publishes the signed
// 2*WIDTH result together with its magnitude and sign.
//
// Compile-time option:
//   MUL_TIMEOUT_EN  when defined, WAIT aborts to ERR after TIMEOUT_CYCLES
//                   cycles without a completion edge and sets the sticky
//                   error flag. When undefined, WAIT waits forever and error
//                   is tied low.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   req           in   one-cycle request pulse
//   num1, num2    in   [WIDTH] signed operands
//   mul_a, mul_b  out  [WIDTH] operand magnitudes to the multiplier
//   mul_load      out  one-cycle start pulse to the multiplier
//   mul_done      in   multiplier done level
//   mul_result    in   [2*WIDTH] unsigned product
//   product_mag   out  [2*WIDTH] magnitude of the last result
//   product       out  [2*WIDTH] two's-complement last result
//   sign          out  last result is negative
//   result_valid  out  one-cycle pulse when results are published
//   busy          out  high in every state except IDLE
//   error         out  sticky timeout flag (cleared by rst only)
// -----------------------------------------------------------------------------
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_load,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic [2*WIDTH-1:0] product_mag,
  output logic [2*WIDTH-1:0] product,
  output logic               sign,
  output logic               result_valid,
  output logic               busy,
  output logic               error
);

  state_t state, state_next;
  logic   pending, pending_next;
  logic   done_prev;
  logic   done_edge;
  logic   latch_en;
  logic   capture;
  logic   timeout;
  logic   res_sign;

  // ---------------------------------------------------------------------------
  // Operand latches: index 0 is operand A (num1), index 1 is operand B (num2)
  // ---------------------------------------------------------------------------
  logic [1:0][WIDTH-1:0] op_in;
  logic [1:0][WIDTH-1:0] op_mag;
  logic [1:0]            op_sgn;

  assign op_in[0] = num1;
  assign op_in[1] = num2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    mul_operand_latch #(
      .WIDTH(WIDTH)
    ) u_latch (
      .clk     (clk),
      .rst     (rst),
      .load    (latch_en),
      .operand (op_in[gi]),
      .sgn     (op_sgn[gi]),
      .mag     (op_mag[gi])
    );
  end

  assign mul_a = op_mag[0];
  assign mul_b = op_mag[1];

  // Only a low-to-high transition counts as completion; a done level left
  // over from a previous operation is not mistaken for a new result.
  assign done_edge = mul_done & ~done_prev;

  // ---------------------------------------------------------------------------
  // Optional WAIT timeout
  // ---------------------------------------------------------------------------
`ifdef MUL_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] timer;

  // Counts cycles spent in WAIT; reaches TIMEOUT_CYCLES-1 on the last cycle
  // before the abort edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state != ST_WAIT) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout = (state == ST_WAIT) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Raised on the edge that enters ERR and held until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (state_next == ST_ERR) begin
      error <= 1'b1;
    end
  end
`else
  // Keeps the timeout parameter referenced in builds without the counter.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);

  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state, pending flag and done-edge register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      done_prev <= mul_done;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    latch_en     = 1'b0;
    capture      = 1'b0;
    mul_load     = 1'b0;
    result_valid = 1'b0;
    busy         = (state != ST_IDLE);

    // A request arriving while an operation is in flight is remembered once;
    // further requests before it is serviced are dropped.
    if (state != ST_IDLE && req) begin
      pending_next = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        pending_next = 1'b0;
        if (req || pending) begin
          state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        latch_en   = 1'b1;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mul_load   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_edge) begin
          capture    = 1'b1;
          state_next = ST_PUBLISH;
        end else if (timeout) begin
          state_next = ST_ERR;
        end
      end
      ST_PUBLISH: begin
        result_valid = 1'b1;
        state_next   = ST_IDLE;
      end
      ST_ERR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded on the completion edge so that they are already
  // valid during the PUBLISH cycle that pulses result_valid.
  // ---------------------------------------------------------------------------
  // A zero product is never reported as negative.
  assign res_sign = (op_sgn[0] ^ op_sgn[1]) && (mul_result != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_mag <= '0;
      product     <= '0;
      sign        <= 1'b0;
    end else if (capture) begin
      product_mag <= mul_result;
      product     <= res_sign ? -mul_result : mul_result;
      sign        <= res_sign;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Self-checking bench for mul_sequencer. A behavioural unsigned multiplier
// answers each mul_load after a programmable delay (or never, in hang mode).
// Directed vectors in a table are applied one request at a time; hand-written
// sequences cover pending requests, reset mid-operation and, when
// MUL_TIMEOUT_EN is defined, the WAIT timeout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_sequencer;

  localparam int W  = 8;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req = 1'b0;
  logic [W-1:0]   num1 = '0;
  logic [W-1:0]   num2 = '0;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_load;
  logic           mul_done = 1'b0;
  logic [2*W-1:0] mul_result = '0;
  logic [2*W-1:0] product_mag, product;
  logic           sign, result_valid, busy, error;

  mul_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .num1         (num1),
    .num2         (num2),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_load     (mul_load),
    .mul_done     (mul_done),
    .mul_result   (mul_result),
    .product_mag  (product_mag),
    .product      (product),
    .sign         (sign),
    .result_valid (result_valid),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural unsigned multiplier ----------------
  int model_delay = 3;
  bit model_hang  = 1'b0;
  int model_cnt   = 0;

  always @(posedge clk) begin
    if (mul_load) begin
      mul_done   <= 1'b0;
      mul_result <= {8'h00, mul_a} * {8'h00, mul_b};
      model_cnt  <= model_hang ? 0 : model_delay;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) mul_done <= 1'b1;
    end
  end

  // ---------------- pulse counters ----------------
  int load_count  = 0;
  int valid_count = 0;

  always @(negedge clk) begin
    if (mul_load)     load_count++;
    if (result_valid) valid_count++;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]   n1;
    logic [W-1:0]   n2;
    logic [W-1:0]   exp_a;
    logic [W-1:0]   exp_b;
    logic [2*W-1:0] exp_mag;
    logic [2*W-1:0] exp_prod;
    logic           exp_sign;
  } vec_t;

  vec_t vecs [6];

  // One request, checked end to end against table entry idx.
  task automatic run_op(input int idx);
    vec_t v;
    int   lc0, vc0;
    bit   got;
    v   = vecs[idx];
    got = 1'b0;
    @(negedge clk); #1;
    lc0  = load_count;
    vc0  = valid_count;
    num1 = v.n1;
    num2 = v.n2;
    req  = 1'b1;
    @(negedge clk); #1;
    req = 1'b0;
    check("busy_after_req", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("mul_load_latency", 32'(mul_load), 32'd1);
    check("mul_a", 32'(mul_a), 32'(v.exp_a));
    check("mul_b", 32'(mul_b), 32'(v.exp_b));
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("result_valid_seen", 32'(got), 32'd1);
    check("product_mag", 32'(product_mag), 32'(v.exp_mag));
    check("product", 32'(product), 32'(v.exp_prod));
    check("sign", 32'(sign), 32'(v.exp_sign));
    $display("op %0d: num1=%h num2=%h mag=%h product=%h sign=%b", idx, v.n1, v.n2,
             product_mag, product, sign);
    @(negedge clk); #1;
    check("result_valid_one_cycle", 32'(result_valid), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
    check("load_pulses", 32'(load_count - lc0), 32'd1);
    check("valid_pulses", 32'(valid_count - vc0), 32'd1);
  endtask

  logic [2*W-1:0] res [4];
  int             nres;
  int             lc0, vc0;
  bit             seen_valid;

  initial begin
    vecs[0] = '{8'h05, 8'hFD, 8'h05, 8'h03, 16'h000F, 16'hFFF1, 1'b1};
    vecs[1] = '{8'h80, 8'h80, 8'h80, 8'h80, 16'h4000, 16'h4000, 1'b0};
    vecs[2] = '{8'h00, 8'hF9, 8'h00, 8'h07, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{8'h7F, 8'h80, 8'h7F, 8'h80, 16'h3F80, 16'hC080, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'h01, 8'h01, 16'h0001, 16'h0001, 1'b0};
    vecs[5] = '{8'h0C, 8'h0A, 8'h0C, 8'h0A, 16'h0078, 16'h0078, 1'b0};

    // ---------------- reset state ----------------
    @(negedge clk); #1;
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_mul_load", 32'(mul_load), 32'd0);
    check("rst_product_mag", 32'(product_mag), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 6; i++) run_op(i);

    // ---------------- pending request / dropped extra request ----------------
    @(negedge clk); #1;
    lc0  = load_count;
    vc0  = valid_count;
    nres = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (result_valid) begin
        if (nres < 4) res[nres] = product;
        nres++;
      end
      req = (i == 0) || (i == 3) || (i == 5);
      if (i == 0) begin num1 = 8'd3; num2 = 8'd4; end
      if (i == 3) begin num1 = 8'd2; num2 = 8'd2; end
    end
    req = 1'b0;
    check("pending_results", 32'(nres), 32'd2);
    check("pending_first", 32'(res[0]), 32'h000C);
    check("pending_second", 32'(res[1]), 32'h0004);
    check("pending_loads", 32'(load_count - lc0), 32'd2);
    $display("pending sequence: results=%0d first=%h second=%h", nres, res[0], res[1]);

    // ---------------- reset in the middle of WAIT ----------------
    model_delay = 8;
    @(negedge clk); #1;
    num1 = 8'd6; num2 = 8'd7; req = 1'b1;
    @(negedge clk); #1; req = 1'b0;   // LATCH
    @(negedge clk); #1;               // ISSUE
    @(negedge clk); #1;               // WAIT
    check("midwait_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_mul_a", 32'(mul_a), 32'd0);
    check("async_rst_product", 32'(product), 32'd0);
    check("async_rst_product_mag", 32'(product_mag), 32'd0);
    @(negedge clk); #1; rst = 1'b0;
    vc0 = valid_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
    end
    check("no_valid_after_rst", 32'(valid_count - vc0), 32'd0);
    check("idle_after_rst", 32'(busy), 32'd0);
    $display("reset mid-wait: late done pulses=%0d", valid_count - vc0);
    model_delay = 3;
    run_op(0);

`ifdef MUL_TIMEOUT_EN
    // ---------------- WAIT timeout ----------------
    model_hang = 1'b1;
    seen_valid = 1'b0;
    @(negedge clk); #1;
    num1 = 8'd9; num2 = 8'd9; req = 1'b1;
    @(negedge clk); #1; req = 1'b0;   // LATCH
    @(negedge clk); #1;               // ISSUE
    check("timeout_mul_load", 32'(mul_load), 32'd1);
    for (int j = 0; j <= TO + 1; j++) begin
      @(negedge clk); #1;
      if (result_valid) seen_valid = 1'b1;
      if (j == TO - 1) check("error_before_timeout", 32'(error), 32'd0);
      if (j == TO) begin
        check("error_at_timeout", 32'(error), 32'd1);
        check("busy_in_err", 32'(busy), 32'd1);
      end
      if (j == TO + 1) check("busy_after_err", 32'(busy), 32'd0);
    end
    check("timeout_no_valid", 32'(seen_valid), 32'd0);
    check("timeout_product_kept", 32'(product), 32'hFFF1);
    check("timeout_mag_kept", 32'(product_mag), 32'h000F);
    check("timeout_sign_kept", 32'(sign), 32'd1);
    $display("timeout: error=%b busy=%b product=%h", error, busy, product);
    model_hang = 1'b0;
    run_op(1);
    check("error_sticky", 32'(error), 32'd1);
`else
    check("error_tied_low", 32'(error), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Controller that sequences one signed 8x8 multiply on the shared unsigned multiplier datapath. It latches both operands on a request and splits each into sign and magnitude. It then issues a one-cycle load to the unsigned multiplier, waits for its completion edge, and publishes the signed 16-bit result, the magnitude and the sign for the BCD/display path. It sits between the debounced load pushbutton and the unsigned multiplier, and replaces the free-running sign logic.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before the controller aborts; only meaningful with MUL_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- req  input  1  one-cycle request pulse (debounced load button)
- num1  input  WIDTH  signed operand A (two's complement)
- num2  input  WIDTH  signed operand B (two's complement)
- mul_a  output  WIDTH  magnitude of A, driven to the multiplier
- mul_b  output  WIDTH  magnitude of B, driven to the multiplier
- mul_load  output  1  one-cycle start pulse to the multiplier
- mul_done  input  1  multiplier done level
- mul_result  input  2*WIDTH  unsigned product from the multiplier
- product_mag  output  2*WIDTH  registered magnitude of the result
- product  output  2*WIDTH  registered two's-complement result
- sign  output  1  1 = result negative
- result_valid  output  1  one-cycle pulse when new results are published
- busy  output  1  high in every state except IDLE
- error  output  1  sticky timeout flag

Behaviour:
- Reset, asynchronous: every output goes to 0, the FSM goes to IDLE, and the pending flag and the done-edge register clear. Reset mid-operation aborts at once with no result_valid.
- FSM states: IDLE, LATCH, ISSUE, WAIT, PUBLISH, ERR.
- IDLE: if req=1 or pending=1, go to LATCH and clear pending.
- LATCH: register num1/num2.
  - sgn_a = num1[WIDTH-1], sgn_b = num2[WIDTH-1].
  - mag = sgn ? -x : x, computed unsigned on WIDTH bits, so -128 gives magnitude 128 (0x80).
  - mul_a and mul_b hold these magnitudes stable until the next LATCH.
  - Next state is ISSUE.
- ISSUE: mul_load=1 for exactly this cycle; next state is WAIT.
- WAIT:
  - Completion is only the rising edge of mul_done, i.e. mul_done=1 and the previous sample=0.
  - A mul_done level that was already high at issue is ignored.
  - On completion, capture mul_result and go to PUBLISH.
- PUBLISH:
  - product_mag = captured value.
  - sign = (sgn_a ^ sgn_b) and (value != 0); a zero product is never negative.
  - product = sign ? -value : value, computed on 2*WIDTH bits.
  - result_valid=1 for this one cycle; next state is IDLE.
- Outputs product, product_mag and sign hold their values until the next PUBLISH.
- Latency:
  - req to mul_load: 2 cycles.
  - mul_done rising edge to result_valid: 1 cycle.
- req while busy: sets pending (one deep; extra reqs are dropped). Operands are resampled in the LATCH that services the pending request, not at the time of the req.
- req in the same cycle as PUBLISH sets pending; IDLE then launches the next operation the cycle after.
- error is cleared only by rst; while error=1, IDLE still accepts new requests.

Optional Feature:
MUL_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse without a completion edge, the FSM goes to ERR.
  - ERR sets error=1, leaves product, product_mag and sign unchanged, suppresses result_valid and returns to IDLE next cycle.
- Undefined: there is no counter, WAIT waits indefinitely, the ERR state is unreachable and error is tied to 0.

Decomposition:
- Shared package mul_pkg holds:
  - the FSM state enum;
  - the WIDTH default;
  - the TIMEOUT_CYCLES default;
  - a function abs_mag(x) returning the unsigned magnitude.
- One sub-module, mul_operand_latch: registers a single operand and produces its sign and magnitude. It is instantiated twice.
- The FSM, pending flag, edge detect and timeout stay in mul_sequencer.

Test Plan:
- num1=5, num2=-3 (0xFD), req → mul_a=5, mul_b=3, one mul_load; model returns 15 → product_mag=15, sign=1, product=0xFFF1, one result_valid.
- num1=-128, num2=-128 → mul_a=mul_b=0x80; model returns 0x4000 → sign=0, product=0x4000.
- num1=0, num2=-7 → result 0, sign=0, product=0x0000.
- Second req 3 cycles after the first, with operands changed to 2 and 2 before the first completes → the first result is published, then a second mul_load fires and product=4; a third req during busy produces no third operation.
- With MUL_TIMEOUT_EN, the model never raises mul_done → error=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; no result_valid; previous outputs unchanged; busy drops the next cycle.
- rst asserted mid-WAIT → all outputs 0 asynchronously; a later mul_done edge produces no result_valid; the next req runs normally.
